// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter with configurable framing
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          TX_start,
  input  logic [DATA_BITS-1:0]          TX_data,
  output logic                          TX,
  output logic                          q_busy,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_done,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];

  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 done;
  logic                 baud_last;
  logic [DATA_BITS-1:0] head;

  assign full      = (count_q == (AW+1)'(FIFO_DEPTH));
  assign push      = TX_start && !full;
  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    baud_d  = baud_last ? '0 : baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: if (baud_last) state_d = DATA;
      DATA: begin
        if (baud_last) begin
          shift_d = shift_q >> 1;
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      PAR: if (baud_last) state_d = STOP;
      STOP: begin
        if (baud_last) begin
          if (bit_q == 4'(STOP_BITS - 1)) begin
            done  = 1'b1;
            bit_d = '0;
            if (count_q != '0) begin
              pop     = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Popping loads the head word and freezes its parity for the whole frame
    if (pop) begin
      shift_d = head;
      par_d   = (PARITY == 1) ? ~^head : ^head;
      baud_d  = '0;
    end
  end

  // TX follows the current state, so the line lags the FSM by one cycle
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      PAR:     tx_d = par_q;
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = TX_start && full;
    if (push) begin
      mem_d[wr_ptr_q] = TX_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign TX         = tx_q;
  assign q_busy     = (state_q != IDLE) || (count_q != '0);
  assign fifo_full  = full;
  assign fifo_count = count_q;
  assign tx_done    = done;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed bench for uart_tx_fifo across four framing configurations
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] start;
  logic [7:0] d [4];
  logic [3:0] tx, q_busy, fifo_full, tx_done, overflow;
  logic [2:0] cnt [4];

  int total  = 0;
  int passed = 0;
  int dones;

  always #5 clk = ~clk;

  // 0: 8N1, 1: 8E1, 2: 8O1, 3: 7N2
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .reset(reset), .TX_start(start[0]), .TX_data(d[0]), .TX(tx[0]),
    .q_busy(q_busy[0]), .fifo_full(fifo_full[0]), .fifo_count(cnt[0]),
    .tx_done(tx_done[0]), .overflow(overflow[0]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .reset(reset), .TX_start(start[1]), .TX_data(d[1]), .TX(tx[1]),
    .q_busy(q_busy[1]), .fifo_full(fifo_full[1]), .fifo_count(cnt[1]),
    .tx_done(tx_done[1]), .overflow(overflow[1]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .reset(reset), .TX_start(start[2]), .TX_data(d[2]), .TX(tx[2]),
    .q_busy(q_busy[2]), .fifo_full(fifo_full[2]), .fifo_count(cnt[2]),
    .tx_done(tx_done[2]), .overflow(overflow[2]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .reset(reset), .TX_start(start[3]), .TX_data(d[3][6:0]), .TX(tx[3]),
    .q_busy(q_busy[3]), .fifo_full(fifo_full[3]), .fifo_count(cnt[3]),
    .tx_done(tx_done[3]), .overflow(overflow[3]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic write(input int i, input logic [7:0] v);
    start[i] = 1'b1;
    d[i]     = v;
    step();
    start[i] = 1'b0;
  endtask

  // Each character of s is one bit period (4 clk) of TX, first character first
  task automatic check_seq(input int i, input string s, input string tag, output int nd);
    nd = 0;
    for (int b = 0; b < s.len(); b++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        chk($sformatf("%s bit%0d cyc%0d", tag, b, c), 32'(tx[i]), 32'(s.getc(b) == 8'h31));
        if (tx_done[i] === 1'b1) nd++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = '0;
    for (int i = 0; i < 4; i++) d[i] = '0;
    step(); step(); step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst tx%0d", i), 32'(tx[i]), 32'd1);
      chk($sformatf("rst busy%0d", i), 32'(q_busy[i]), 32'd0);
      chk($sformatf("rst full%0d", i), 32'(fifo_full[i]), 32'd0);
      chk($sformatf("rst cnt%0d", i), 32'(cnt[i]), 32'd0);
      chk($sformatf("rst done%0d", i), 32'(tx_done[i]), 32'd0);
      chk($sformatf("rst ovf%0d", i), 32'(overflow[i]), 32'd0);
    end
    reset = 1'b0;
    step();

    // 1: 8N1 0xA5
    write(0, 8'hA5);
    chk("t1 cnt after write", 32'(cnt[0]), 32'd1);
    chk("t1 busy after write", 32'(q_busy[0]), 32'd1);
    chk("t1 tx idle n", 32'(tx[0]), 32'd1);
    step();
    chk("t1 tx idle n+1", 32'(tx[0]), 32'd1);
    check_seq(0, "0101001011", "t1", dones);
    chk("t1 done pulses", 32'(dones), 32'd1);
    chk("t1 busy after frame", 32'(q_busy[0]), 32'd0);
    chk("t1 tx after frame", 32'(tx[0]), 32'd1);
    step(); step();

    // 2: parity even then odd on 0x07
    write(1, 8'h07);
    step();
    check_seq(1, "01110000011", "t2 even", dones);
    chk("t2 even done", 32'(dones), 32'd1);
    chk("t2 even busy", 32'(q_busy[1]), 32'd0);
    write(2, 8'h07);
    step();
    check_seq(2, "01110000001", "t2 odd", dones);
    chk("t2 odd done", 32'(dones), 32'd1);
    chk("t2 odd busy", 32'(q_busy[2]), 32'd0);
    step();

    // 3: back-to-back frames
    write(0, 8'hA5);
    write(0, 8'h3C);
    check_seq(0, "01010010110001111001", "t3", dones);
    chk("t3 done pulses", 32'(dones), 32'd2);
    chk("t3 busy after", 32'(q_busy[0]), 32'd0);
    step();

    // 4: overflow while a frame is in flight
    write(0, 8'h11);
    step();
    check_seq(0, "010", "t4 head", dones);
    write(0, 8'h01);
    write(0, 8'h02);
    write(0, 8'h03);
    chk("t4 not full at 3", 32'(fifo_full[0]), 32'd0);
    write(0, 8'h04);
    chk("t4 full", 32'(fifo_full[0]), 32'd1);
    chk("t4 cnt 4", 32'(cnt[0]), 32'd4);
    chk("t4 no ovf yet", 32'(overflow[0]), 32'd0);
    write(0, 8'h05);
    chk("t4 ovf pulse", 32'(overflow[0]), 32'd1);
    chk("t4 cnt still 4", 32'(cnt[0]), 32'd4);
    step();
    chk("t4 ovf cleared", 32'(overflow[0]), 32'd0);
    step(); step();
    check_seq(0, {"10001", "0100000001", "0010000001", "0110000001", "0001000001", "111"},
              "t4 tail", dones);
    chk("t4 done pulses", 32'(dones), 32'd5);
    chk("t4 busy after", 32'(q_busy[0]), 32'd0);

    // 5: reset mid-frame drops the frame and the queue
    write(0, 8'hA5);
    write(0, 8'h3C);
    check_seq(0, "0101", "t5 pre", dones);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5 tx", 32'(tx[0]), 32'd1);
    chk("t5 cnt", 32'(cnt[0]), 32'd0);
    chk("t5 busy", 32'(q_busy[0]), 32'd0);
    chk("t5 full", 32'(fifo_full[0]), 32'd0);
    check_seq(0, "11111", "t5 quiet", dones);
    chk("t5 no done", 32'(dones), 32'd0);
    chk("t5 busy end", 32'(q_busy[0]), 32'd0);

    // 6: 7 data bits, 2 stop bits
    write(3, 8'h55);
    step();
    check_seq(3, "0101010111", "t6", dones);
    chk("t6 done pulses", 32'(dones), 32'd1);
    chk("t6 busy after", 32'(q_busy[3]), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
